nco_freq_meas: RTL and testbench
================================

// Module: nco_freq_meas
// PURPOSE
//  Inverse of the NCO: consumes a signed sine sample stream (NCO fsin_o/out_valid format) and
//  estimates the phase increment that produced it. Detects rising zero crossings with hysteresis,
//  counts samples over NPER periods, then divides serially to give phi_inc = 2^APR*NPER/T.
//  Sits in the FIR test bench loop to check NCO setup and measure filter output frequency.
// PARAMETERS
//  MPR      24   input sample width (signed, two's complement)
//  APR      16   phase-increment width; result units match NCO phi_inc_i
//  LOG2NPER 4    log2 of periods averaged; NPER = 2^LOG2NPER
//  CW       24   sample-counter width; the timeout fires at 2^CW-1 samples
//  HYST     256  hysteresis magnitude in LSBs (unsigned, < 2^(MPR-1))
// PORTS
//  clk        in   1    clock
//  reset      in   1    synchronous reset, active-high
//  clken      in   1    global enable; no state changes while 0
//  fsin_i     in   MPR  signed sample
//  in_valid   in   1    fsin_i valid; sample consumed when clken & in_valid
//  phi_inc_o  out  APR  measured phase increment, held between results
//  out_valid  out  1    1-cycle pulse when phi_inc_o updates
//  busy       out  1    1 in MEAS or DIV
//  no_signal  out  1    sticky timeout flag; cleared by reset or next out_valid
// BEHAVIOUR
//  Interface: one clock, clk. Reset is synchronous and active-high.
//  Reset: phi_inc_o=0, out_valid=0, busy=0, no_signal=0, FSM=IDLE, armed=0, counters=0.
//  All registers advance only when clken=1. out_valid is a pulse of one clken-qualified cycle.
//  Crossing detector (runs in IDLE and MEAS, on consumed samples only):
//   - armed is set when fsin_i < -HYST.
//   - xing=1 when armed & fsin_i >= +HYST; the same sample clears armed.
//   - Samples in (-HYST, +HYST) change nothing.
//  FSM:
//   - IDLE: on xing -> MEAS. cnt=0, nx=0.
//   - MEAS: each consumed sample does cnt+=1. On xing, nx+=1.
//     - If nx reaches NPER on that sample: T=cnt (including that sample) -> DIV.
//     - If cnt reaches 2^CW-1 before that: no_signal=1 -> IDLE, armed=0.
//   - DIV: bit-serial restoring divide of N=2^(APR+LOG2NPER) by T, one quotient bit per cycle,
//     MSB first, exactly APR cycles.
//     - If T <= NPER (quotient >= 2^APR), skip the divide and saturate the result to 2^APR-1.
//     - On completion: phi_inc_o=q, out_valid=1, no_signal=0 -> IDLE, armed=0.
//   - Samples arriving during DIV are ignored; in_valid has no backpressure.
//  Latency: out_valid appears APR+1 clken cycles after the consumed sample that completes NPER periods.
//  T = sample-index difference between the 1st and (NPER+1)th crossings.
//  Result is floor(2^APR*NPER/T) with no rounding.
//  Reset mid-MEAS/DIV aborts the operation. No partial result is output; phi_inc_o returns to 0.
//  in_valid=0 or clken=0 stalls counting without corrupting cnt or the divider.
// TESTING
//  1. NCO phi_inc=0x0400 (period 64), in_valid=1 -> T=1024, phi_inc_o=0x0400, out_valid 17 cycles after 17th xing.
//  2. NCO phi_inc=0x0333 -> phi_inc_o within +/-1 LSB of 0x0333; repeated results are identical.
//  3. in_valid toggled 50% with phi_inc=0x0400 -> same result 0x0400. clken gaps -> same result.
//  4. DC input 0, CW=12 build -> no_signal=1 after 4095 counted samples (after initial xing).
//     No out_valid; a later valid tone clears no_signal with its result.
//  5. Sine 0x0400 plus +/-(HYST-1) dither around zero crossings -> no extra crossings; result 0x0400.
//  6. reset asserted mid-DIV -> next cycle busy=0, phi_inc_o=0, no out_valid; next measurement is correct.

Source files
------------

// File: rtl/nco_freq_meas.sv
// nco_freq_meas: estimates an NCO phase increment from its sine output by timing NPER rising
// zero crossings (with hysteresis) and dividing 2^(APR+LOG2NPER) by the period sample count.
module nco_freq_meas #(
  parameter int MPR      = 24,
  parameter int APR      = 16,
  parameter int LOG2NPER = 4,
  parameter int CW       = 24,
  parameter int HYST     = 256
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           clken,
  input  logic [MPR-1:0] fsin_i,
  input  logic           in_valid,
  output logic [APR-1:0] phi_inc_o,
  output logic           out_valid,
  output logic           busy,
  output logic           no_signal
);
  localparam int KW = $clog2(APR + 1);
  localparam logic signed [MPR-1:0] HP = MPR'(HYST);
  localparam logic signed [MPR-1:0] HN = -HP;
  localparam logic [LOG2NPER:0] NX_END = (LOG2NPER + 1)'(1 << LOG2NPER);
  typedef enum logic [1:0] {IDLE, MEAS, DIV} state_t;
  state_t          state_q, state_d;
  logic            armed_q, armed_d, sat_q, sat_d, ov_q, ov_d, ns_q, ns_d;
  logic [CW-1:0]   cnt_q, cnt_d, t_q, t_d, rem_q, rem_d, cnt_inc;
  logic [LOG2NPER:0] nx_q, nx_d, nx_inc;
  logic [APR-1:0]  quo_q, quo_d, phi_q, phi_d;
  logic [KW-1:0]   k_q, k_d;
  logic [CW:0]     rem_sh;
  logic            take, neg, pos, xing, ge;
  assign take    = in_valid && state_q != DIV;
  assign neg     = $signed(fsin_i) < HN;
  assign pos     = $signed(fsin_i) >= HP;
  assign xing    = take && armed_q && pos;
  assign cnt_inc = cnt_q + CW'(1);
  assign nx_inc  = nx_q + (LOG2NPER + 1)'(1);
  // Remainder stays below T, so one extra bit holds the shifted value for the trial subtract.
  assign rem_sh  = {rem_q, 1'b0};
  assign ge      = rem_sh >= {1'b0, t_q};
  always_comb begin
    state_d = state_q;
    armed_d = take ? (neg || (armed_q && !pos)) : armed_q;
    cnt_d   = cnt_q;
    nx_d    = nx_q;
    t_d     = t_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    k_d     = k_q;
    sat_d   = sat_q;
    phi_d   = phi_q;
    ns_d    = ns_q;
    ov_d    = 1'b0;
    case (state_q)
      IDLE: if (xing) begin
        state_d = MEAS;
        cnt_d   = '0;
        nx_d    = '0;
      end
      MEAS: if (take) begin
        cnt_d = cnt_inc;
        nx_d  = xing ? nx_inc : nx_q;
        if (xing && nx_inc == NX_END) begin
          state_d = DIV;
          t_d     = cnt_inc;
          rem_d   = CW'(1 << LOG2NPER);
          quo_d   = '0;
          k_d     = '0;
          sat_d   = cnt_inc <= CW'(1 << LOG2NPER);
        end else if (cnt_inc == '1) begin
          state_d = IDLE;
          ns_d    = 1'b1;
          armed_d = 1'b0;
        end
      end
      DIV: if (k_q == KW'(APR)) begin
        state_d = IDLE;
        phi_d   = sat_q ? '1 : quo_q;
        ov_d    = 1'b1;
        ns_d    = 1'b0;
        armed_d = 1'b0;
      end else begin
        rem_d = ge ? CW'(rem_sh - {1'b0, t_q}) : rem_sh[CW-1:0];
        quo_d = APR'({quo_q, ge});
        k_d   = k_q + KW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      armed_q <= 1'b0;
      cnt_q   <= '0;
      nx_q    <= '0;
      t_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      k_q     <= '0;
      sat_q   <= 1'b0;
      phi_q   <= '0;
      ov_q    <= 1'b0;
      ns_q    <= 1'b0;
    end else if (clken) begin
      state_q <= state_d;
      armed_q <= armed_d;
      cnt_q   <= cnt_d;
      nx_q    <= nx_d;
      t_q     <= t_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      k_q     <= k_d;
      sat_q   <= sat_d;
      phi_q   <= phi_d;
      ov_q    <= ov_d;
      ns_q    <= ns_d;
    end
  end
  assign phi_inc_o = phi_q;
  assign out_valid = ov_q;
  assign busy      = state_q != IDLE;
  assign no_signal = ns_q;
endmodule

// File: tb/tb_nco_freq_meas.sv
// tb_nco_freq_meas: directed scenarios against a default build and a CW=12 build sharing inputs.
module tb_nco_freq_meas;
  logic        clk = 1'b0;
  logic        reset = 1'b1, clken = 1'b1, in_valid = 1'b0;
  logic [23:0] fsin_i = '0;
  logic [15:0] phi_a, phi_b;
  logic        ov_a, busy_a, ns_a, ov_b, busy_b, ns_b;
  int          checks = 0, fails = 0, cyc = 0, res_cyc = 0, t0, got;
  logic [15:0] res_a[$], res_b[$];
  localparam real AMP = 4194304.0;

  nco_freq_meas u_dut (.clk(clk), .reset(reset), .clken(clken), .fsin_i(fsin_i),
    .in_valid(in_valid), .phi_inc_o(phi_a), .out_valid(ov_a), .busy(busy_a), .no_signal(ns_a));
  nco_freq_meas #(.CW(12)) u_dut12 (.clk(clk), .reset(reset), .clken(clken), .fsin_i(fsin_i),
    .in_valid(in_valid), .phi_inc_o(phi_b), .out_valid(ov_b), .busy(busy_b), .no_signal(ns_b));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (clken && ov_a) begin
      res_a.push_back(phi_a);
      res_cyc = cyc;
    end
    if (clken && ov_b) res_b.push_back(phi_b);
  end

  // kind 0: sine, 1: +/-1000 square (period 2), 2: one crossing then DC zero
  function automatic logic [23:0] sample(input int kind, input int phi, input real amp,
                                         input bit dith, input int idx);
    real x;
    int s;
    if (kind == 1) s = idx[0] ? 1000 : -1000;
    else if (kind == 2) s = (idx == 0) ? -1000 : (idx == 1) ? 1000 : 0;
    else begin
      x = amp * $sin(2.0 * 3.141592653589793 * real'((idx * phi) % 65536) / 65536.0);
      s = $rtoi(x + ((x >= 0.0) ? 0.5 : -0.5));
      if (dith && s > -256 && s < 256) s = idx[0] ? 255 : -255;
    end
    return s[23:0];
  endfunction

  task automatic drive(input int kind, input int phi, input real amp, input bit dith,
                       input bit vmode, input bit cmode, input int n0, input int n1);
    int idx = n0;
    int c = 0;
    while (idx < n1) begin
      clken = !cmode || (c % 3 != 2);
      in_valid = !vmode || c[0];
      fsin_i = sample(kind, phi, amp, dith, idx);
      @(posedge clk); #1;
      if (clken && in_valid) idx++;
      c++;
    end
    clken = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic wait_res(input int n, input bit use_b);
    int i = 0;
    while (((use_b ? res_b.size() : res_a.size()) < n) && i < 300) begin
      @(posedge clk); #1;
      i++;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    clken = 1'b1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    res_a.delete();
    res_b.delete();
  endtask

  task automatic test_reset;
    do_reset;
    checks++;
    if ({phi_a, ov_a, busy_a, ns_a} !== 19'd0) begin
      fails++;
      $display("FAIL reset_a: got phi=%h ov=%b busy=%b ns=%b expected all 0", phi_a, ov_a, busy_a, ns_a);
    end
    checks++;
    if ({phi_b, ov_b, busy_b, ns_b} !== 19'd0) begin
      fails++;
      $display("FAIL reset_b: got phi=%h ov=%b busy=%b ns=%b expected all 0", phi_b, ov_b, busy_b, ns_b);
    end
  endtask

  task automatic test_basic;
    do_reset;
    drive(0, 'h400, AMP, 0, 0, 0, 0, 1090);
    t0 = cyc;
    checks++;
    if (busy_a !== 1'b1) begin fails++; $display("FAIL basic_busy: got %b expected 1", busy_a); end
    wait_res(1, 0);
    got = res_a.size() > 0 ? int'(res_a[0]) : -1;
    checks++;
    if (got !== 'h400) begin fails++; $display("FAIL basic_phi: got %h expected 0400", got); end
    checks++;
    if (res_cyc - t0 !== 17) begin fails++; $display("FAIL basic_latency: got %0d expected 17", res_cyc - t0); end
    checks++;
    if ({busy_a, ns_a} !== 2'b00) begin fails++; $display("FAIL basic_idle: got busy=%b ns=%b expected 0 0", busy_a, ns_a); end
  endtask

  task automatic test_fractional;
    do_reset;
    drive(0, 'h333, AMP, 0, 0, 0, 0, 3000);
    wait_res(2, 0);
    checks++;
    if (res_a.size() < 2) begin fails++; $display("FAIL frac_count: got %0d expected >=2", res_a.size()); end
    for (int i = 0; i < 2; i++) begin
      got = res_a.size() > i ? int'(res_a[i]) : -1;
      checks++;
      if (got < 'h332 || got > 'h334) begin
        fails++;
        $display("FAIL frac_phi%0d: got %h expected 0333 +/-1", i, got);
      end
    end
  endtask

  task automatic test_stalls;
    do_reset;
    drive(0, 'h400, AMP, 0, 1, 0, 0, 1100);
    wait_res(1, 0);
    got = res_a.size() > 0 ? int'(res_a[0]) : -1;
    checks++;
    if (got !== 'h400) begin fails++; $display("FAIL in_valid_gap_phi: got %h expected 0400", got); end
    do_reset;
    drive(0, 'h400, AMP, 0, 0, 1, 0, 1100);
    wait_res(1, 0);
    got = res_a.size() > 0 ? int'(res_a[0]) : -1;
    checks++;
    if (got !== 'h400) begin fails++; $display("FAIL clken_gap_phi: got %h expected 0400", got); end
    checks++;
    if (res_a.size() !== 1) begin fails++; $display("FAIL clken_gap_count: got %0d expected 1", res_a.size()); end
  endtask

  task automatic test_timeout;
    do_reset;
    drive(2, 0, 0.0, 0, 0, 0, 0, 4096);
    checks++;
    if ({ns_b, busy_b} !== 2'b01) begin fails++; $display("FAIL tmo_before: got ns=%b busy=%b expected 0 1", ns_b, busy_b); end
    drive(2, 0, 0.0, 0, 0, 0, 4096, 4097);
    checks++;
    if ({ns_b, busy_b} !== 2'b10) begin fails++; $display("FAIL tmo_fire: got ns=%b busy=%b expected 1 0", ns_b, busy_b); end
    checks++;
    if (res_b.size() !== 0) begin fails++; $display("FAIL tmo_no_result: got %0d results expected 0", res_b.size()); end
    drive(0, 'h400, AMP, 0, 0, 0, 0, 1100);
    wait_res(1, 1);
    got = res_b.size() > 0 ? int'(res_b[0]) : -1;
    checks++;
    if (got !== 'h400) begin fails++; $display("FAIL tmo_recover_phi: got %h expected 0400", got); end
    checks++;
    if (ns_b !== 1'b0) begin fails++; $display("FAIL tmo_clear: got %b expected 0", ns_b); end
  endtask

  task automatic test_dither;
    do_reset;
    drive(0, 'h400, 2000.0, 1, 0, 0, 0, 1100);
    wait_res(1, 0);
    got = res_a.size() > 0 ? int'(res_a[0]) : -1;
    checks++;
    if (got !== 'h400) begin fails++; $display("FAIL dither_phi: got %h expected 0400", got); end
    checks++;
    if (res_a.size() !== 1) begin fails++; $display("FAIL dither_count: got %0d expected 1", res_a.size()); end
  endtask

  task automatic test_max_freq;
    do_reset;
    drive(1, 0, 0.0, 0, 0, 0, 0, 40);
    wait_res(1, 0);
    got = res_a.size() > 0 ? int'(res_a[0]) : -1;
    checks++;
    if (got !== 'h8000) begin fails++; $display("FAIL maxfreq_phi: got %h expected 8000", got); end
  endtask

  task automatic test_reset_mid_div;
    res_a.delete();
    drive(0, 'h400, AMP, 0, 0, 0, 0, 1095);
    checks++;
    if ({busy_a, phi_a} !== {1'b1, 16'h0400}) begin
      fails++;
      $display("FAIL middiv_pre: got busy=%b phi=%h expected 1 0400", busy_a, phi_a);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    checks++;
    if ({busy_a, phi_a, ov_a} !== 18'd0) begin
      fails++;
      $display("FAIL middiv_abort: got busy=%b phi=%h ov=%b expected 0 0000 0", busy_a, phi_a, ov_a);
    end
    repeat (30) @(posedge clk);
    #1;
    checks++;
    if (res_a.size() !== 0) begin fails++; $display("FAIL middiv_no_result: got %0d expected 0", res_a.size()); end
    drive(0, 'h400, AMP, 0, 0, 0, 0, 1100);
    wait_res(1, 0);
    got = res_a.size() > 0 ? int'(res_a[0]) : -1;
    checks++;
    if (got !== 'h400) begin fails++; $display("FAIL middiv_remeasure: got %h expected 0400", got); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_fractional;
    test_stalls;
    test_timeout;
    test_max_freq;
    test_dither;
    test_reset_mid_div;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
